operand_loader: RTL and testbench



---
 rtl/operand_loader.sv | 188 ++++++++++++++++++
 tb/tb_operand_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// operand_loader: turns the raw A/B/X push buttons into debounced single-cycle
// press events in the clk domain. It captures operands A and B and the opcode
// from the switch bank, and issues a one-cycle start pulse, or an err pulse,
// to the ALU.
// Optional feature: define OPERAND_AUTOCLEAR_EN to drop back to EMPTY the cycle
// after a start, so that both operands must be reloaded before the next execute.
module operand_loader #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sw,
    input  logic        btn_a,
    input  logic        btn_b,
    input  logic        btn_x,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [3:0]  op,
    output logic        start,
    output logic        err,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StGotA  = 2'd1,
        StGotB  = 2'd2,
        StReady = 2'd3
    } state_t;

    localparam int unsigned IdxA = 0;
    localparam int unsigned IdxB = 1;
    localparam int unsigned IdxX = 2;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

    logic [2:0]       w_btn_raw;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_stable;
    logic [2:0]       r_prev;
    logic [2:0]       r_press;
    logic [CNT_W-1:0] r_cnt [3];

    state_t      r_state;
    state_t      w_state_next;
    state_t      w_base;
    logic        w_start_next;
    logic        w_err_next;
    logic        r_start;
    logic        r_err;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_op;

    assign w_btn_raw = {btn_x, btn_b, btn_a};

    // Two-flop synchronizer per button; the raw buttons are asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: a level change is accepted only after DB_CYCLES consecutive mismatching cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CntMax) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising-edge detect on the stable level; releases produce no event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev  <= '0;
            r_press <= '0;
        end else begin
            r_prev  <= r_stable;
            r_press <= r_stable & ~r_prev;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus the execute decision; the decision always looks at the pre-cycle state.
    always_comb begin
`ifdef OPERAND_AUTOCLEAR_EN
        w_base = r_start ? StEmpty : r_state;
`else
        w_base = r_state;
`endif
        w_state_next = w_base;
        w_start_next = 1'b0;
        w_err_next   = 1'b0;

        if (r_press[IdxX]) begin
            if (r_state == StReady) begin
                w_start_next = 1'b1;
            end else begin
                w_err_next = 1'b1;
            end
        end

        unique case (w_base)
            StEmpty: begin
                if (r_press[IdxA] && r_press[IdxB]) begin
                    w_state_next = StReady;
                end else if (r_press[IdxA]) begin
                    w_state_next = StGotA;
                end else if (r_press[IdxB]) begin
                    w_state_next = StGotB;
                end
            end
            StGotA: begin
                if (r_press[IdxB]) begin
                    w_state_next = StReady;
                end
            end
            StGotB: begin
                if (r_press[IdxA]) begin
                    w_state_next = StReady;
                end
            end
            StReady: begin
                w_state_next = StReady;
            end
            default: begin
                w_state_next = StEmpty;
            end
        endcase
    end

    // Operand/opcode registers and the registered start/err pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_start <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_start <= w_start_next;
            r_err   <= w_err_next;
            if (r_press[IdxA]) begin
                r_a <= sw;
            end
            if (r_press[IdxB]) begin
                r_b <= sw;
            end
            if (w_start_next) begin
                r_op <= sw[3:0];
            end
        end
    end

    assign a     = r_a;
    assign b     = r_b;
    assign op    = r_op;
    assign start = r_start;
    assign err   = r_err;
    assign state = r_state;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader with a short debounce (DB_CYCLES=4).
// Expected start/err pulses are queued as stimulus is applied and popped when the DUT pulses.
module tb_operand_loader;

    localparam int unsigned DbCycles = 4;

    logic        clk;
    logic        rst;
    logic [31:0] sw;
    logic        btn_a;
    logic        btn_b;
    logic        btn_x;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        start;
    logic        err;
    logic [1:0]  state;

    operand_loader #(
        .DB_CYCLES(DbCycles),
        .CNT_W    (3)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .btn_a(btn_a),
        .btn_b(btn_b),
        .btn_x(btn_x),
        .a    (a),
        .b    (b),
        .op   (op),
        .start(start),
        .err  (err),
        .state(state)
    );

    typedef struct packed {
        logic        is_start;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [3:0]  eop;
        logic [1:0]  est;
    } exp_t;

    exp_t exp_q[$];

    int n_vec;
    int n_bad;

    // Reference model of the architectural state.
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [3:0]  m_op;
    logic [1:0]  m_st;

`ifdef OPERAND_AUTOCLEAR_EN
    localparam bit AutoClear = 1'b1;
`else
    localparam bit AutoClear = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_arch(input string pfx, input logic [31:0] ea, input logic [31:0] eb,
                              input logic [3:0] eop, input logic [1:0] est);
        check_val({pfx, "_a"}, a, ea);
        check_val({pfx, "_b"}, b, eb);
        check_val({pfx, "_op"}, {28'd0, op}, {28'd0, eop});
        check_val({pfx, "_state"}, {30'd0, state}, {30'd0, est});
    endtask

    task automatic model_reset();
        m_a  = '0;
        m_b  = '0;
        m_op = '0;
        m_st = 2'd0;
    endtask

    // Hold the chosen buttons until the press takes effect, checking the edge before and the edge of the action.
    task automatic do_press(input logic pa, input logic pb, input logic px, input logic [31:0] v);
        logic [31:0] na;
        logic [31:0] nb;
        logic [3:0]  nop;
        logic [1:0]  act_st;
        logic [1:0]  fin_st;
        exp_t        e;
        na     = pa ? v : m_a;
        nb     = pb ? v : m_b;
        nop    = m_op;
        act_st = m_st | {pb, pa};
        fin_st = act_st;
        if (px) begin
            if (m_st == 2'd3) begin
                nop    = v[3:0];
                act_st = 2'd3;
                fin_st = AutoClear ? 2'd0 : 2'd3;
                e      = '{is_start: 1'b1, ea: na, eb: nb, eop: nop, est: act_st};
            end else begin
                e = '{is_start: 1'b0, ea: na, eb: nb, eop: nop, est: act_st};
            end
            exp_q.push_back(e);
        end
        sw    = v;
        btn_a = pa;
        btn_b = pb;
        btn_x = px;
        repeat (DbCycles + 3) step();
        check_arch("pre", m_a, m_b, m_op, m_st);
        step();
        check_arch("post", na, nb, nop, act_st);
        btn_a = 1'b0;
        btn_b = 1'b0;
        btn_x = 1'b0;
        repeat (12) step();
        check_val("settle_state", {30'd0, state}, {30'd0, fin_st});
        m_a  = na;
        m_b  = nb;
        m_op = nop;
        m_st = fin_st;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        check_arch("rst", 32'd0, 32'd0, 4'd0, 2'd0);
        check_val("rst_start", {31'd0, start}, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);
        model_reset();
        step();
        rst = 1'b0;
    endtask

    // Scoreboard side: every start/err pulse must match the oldest queued expectation.
    always begin
        @(posedge clk);
        #1;
        if (!rst && (start || err)) begin
            if (exp_q.size() == 0) begin
                check_val("pulse_unexpected", {31'd0, start | err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("pulse_start", {31'd0, start}, {31'd0, e.is_start});
                check_val("pulse_err", {31'd0, err}, {31'd0, ~e.is_start});
                check_arch("pulse", e.ea, e.eb, e.eop, e.est);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        sw    = '0;
        btn_a = 1'b0;
        btn_b = 1'b0;
        btn_x = 1'b0;
        model_reset();
        repeat (2) step();
        apply_reset();

        // Load A; the pre/post checks pin the DB_CYCLES+3 latency.
        do_press(1'b1, 1'b0, 1'b0, 32'h0000_0012);

        // A glitch one cycle shorter than the debounce window is discarded.
        btn_b = 1'b1;
        sw    = 32'h0000_00AA;
        repeat (DbCycles - 1) step();
        btn_b = 1'b0;
        repeat (12) step();
        check_arch("glitch", m_a, m_b, m_op, m_st);

        do_press(1'b1, 1'b0, 1'b0, 32'd5);
        do_press(1'b0, 1'b1, 1'b0, 32'd3);
        do_press(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF2);
        do_press(1'b0, 1'b0, 1'b1, 32'h0000_0009);

        // Execute from EMPTY yields err only.
        apply_reset();
        do_press(1'b0, 1'b0, 1'b1, 32'h0000_0007);

        // Simultaneous A and B loads move EMPTY straight to READY.
        do_press(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);

        // Load together with execute: start pairs with the freshly loaded operand.
        do_press(1'b1, 1'b0, 1'b1, 32'h1234_5675);
        do_press(1'b0, 1'b1, 1'b0, 32'h0BAD_CAFE);

        // Reset in the middle of a debounce, button still held afterwards.
        sw    = 32'h0000_0077;
        btn_a = 1'b1;
        repeat (4) step();
        apply_reset();
        repeat (DbCycles + 3) step();
        check_val("rst_mid_pre_a", a, 32'd0);
        step();
        check_val("rst_mid_post_a", a, 32'h0000_0077);
        check_val("rst_mid_state", {30'd0, state}, 32'd1);
        btn_a = 1'b0;
        repeat (12) step();

        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
